// File: rtl/bsm_seq_ctrl.sv
// Operand sequencer for one bit-serial fp16 x intN multiplier lane.
// Optional op counter (perf_ops/perf_clr) is enabled by defining BSM_SEQ_CTRL_PERF_EN.
module bsm_seq_ctrl #(
  parameter int unsigned ACT_WIDTH  = 16,
  parameter int unsigned W_MAX      = 8,
  parameter int unsigned MANT_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_set,
  input  logic [3:0]            cfg_precision,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACT_WIDTH-1:0]  in_act,
  input  logic [W_MAX-1:0]      in_w,
  output logic [ACT_WIDTH-1:0]  mul_act,
  output logic                  mul_w,
  output logic                  mul_valid,
  output logic                  mul_set,
  output logic [3:0]            mul_precision,
  input  logic                  mul_sign,
  input  logic [MANT_WIDTH-1:0] mul_mant,
  input  logic                  mul_start_acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [4:0]            out_exp,
  output logic [MANT_WIDTH-1:0] out_mant,
  output logic                  out_err,
`ifdef BSM_SEQ_CTRL_PERF_EN
  input  logic                  perf_clr,
  output logic [15:0]           perf_ops,
`endif
  output logic                  busy
);

  localparam int unsigned IDX_W  = (W_MAX > 1) ? $clog2(W_MAX) : 1;
  localparam int unsigned PREC_W = 4;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned WD_W   = 2;
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(3);
  localparam logic [PREC_W-1:0] PREC_RST  = PREC_W'(4);
  localparam logic [PREC_W-1:0] PREC_MIN  = PREC_W'(2);
  localparam logic [PREC_W-1:0] PREC_MAX  = PREC_W'(W_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPT} state_t;

  state_t               state, state_nx;
  logic [PREC_W-1:0]    prec_reg;
  logic [ACT_WIDTH-1:0] act_reg;
  logic [W_MAX-1:0]     w_reg;
  logic [IDX_W-1:0]     idx;
  logic                 sign_reg;
  logic [WD_W-1:0]      wd_cnt;
  logic                 cfg_take, accept, capture, abort;
  logic                 first_shift;

  function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] p);
    if (p < PREC_MIN) return PREC_MIN;
    if (p > PREC_MAX) return PREC_MAX;
    return p;
  endfunction

  assign busy        = (state != IDLE);
  assign mul_act     = act_reg;
  assign first_shift = (PREC_W'(idx) == prec_reg - PREC_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state, handshake and lane drive
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    mul_valid = 1'b0;
    mul_w     = 1'b0;
    cfg_take  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        cfg_take = cfg_set;
        in_ready = !cfg_set && (!out_valid || out_ready);
        accept   = in_ready && in_valid;
        if (accept) state_nx = SHIFT;
      end
      SHIFT: begin
        mul_valid = 1'b1;
        mul_w     = w_reg[idx];
        if (idx == '0) state_nx = CAPT;
      end
      CAPT: begin
        if (mul_start_acc) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand, precision and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prec_reg      <= PREC_RST;
      mul_precision <= PREC_RST;
      mul_set       <= 1'b0;
      act_reg       <= '0;
      w_reg         <= '0;
      idx           <= '0;
      sign_reg      <= 1'b0;
      wd_cnt        <= '0;
      out_valid     <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_mant      <= '0;
      out_err       <= 1'b0;
    end else begin
      mul_set <= cfg_take;
      if (cfg_take) begin
        prec_reg      <= clamp_prec(cfg_precision);
        mul_precision <= clamp_prec(cfg_precision);
      end
      if (accept) begin
        act_reg <= in_act;
        w_reg   <= in_w;
        idx     <= IDX_W'(prec_reg - PREC_W'(1));
      end else if (state == SHIFT && idx != '0) begin
        idx <= idx - IDX_W'(1);
      end
      // Lane sign is only meaningful while the weight sign bit is on the wire
      if (state == SHIFT && first_shift) sign_reg <= mul_sign;
      wd_cnt <= (state == CAPT) ? wd_cnt + WD_W'(1) : '0;
      if (capture) begin
        out_valid <= 1'b1;
        out_sign  <= sign_reg;
        out_exp   <= act_reg[ACT_WIDTH-2 -: EXP_W];
        out_mant  <= mul_mant;
        out_err   <= 1'b0;
      end else if (abort) begin
        out_valid <= 1'b1;
        out_sign  <= 1'b0;
        out_exp   <= '0;
        out_mant  <= '0;
        out_err   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BSM_SEQ_CTRL_PERF_EN
  // Saturating count of drained results; clear has priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               perf_ops <= '0;
    else if (perf_clr)                                      perf_ops <= '0;
    else if (out_valid && out_ready && perf_ops != 16'hFFFF) perf_ops <= perf_ops + 16'd1;
  end
`endif

endmodule
